rst_seq: RTL and testbench

//  Reset release sequencer; generates the resets that per-domain synchronizers and blocks consume.

---
 rtl/rst_seq_if.sv | 31 +++
 rtl/rst_seq.sv | 154 +++++++++++++++
 tb/tb_rst_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rst_seq_if.sv
// Reset sequencer control/status bundle.
// master: drives software reset request and per-domain ready.
// slave : the sequencer, drives per-domain resets and status flags.
interface rst_seq_if #(
    parameter int NUM_DOM = 3
);
    logic               sw_rst_req;
    logic [NUM_DOM-1:0] dom_rdy_i;
    logic [NUM_DOM-1:0] dom_rst_o;
    logic               all_rdy_o;
    logic               busy_o;
    logic               err_o;

    modport master (
        output sw_rst_req,
        output dom_rdy_i,
        input  dom_rst_o,
        input  all_rdy_o,
        input  busy_o,
        input  err_o
    );

    modport slave (
        input  sw_rst_req,
        input  dom_rdy_i,
        output dom_rst_o,
        output all_rdy_o,
        output busy_o,
        output err_o
    );
endinterface

// File: rtl/rst_seq.sv
// Reset release sequencer.
// Holds every domain reset for HOLD_CYC edges, then releases domains in
// order (domain 0 first), waiting for each domain's ready and a STEP_CYC gap
// before releasing the next. A software request restarts the sequence.
// Optional macro RST_SEQ_TIMEOUT_EN: bound the ready wait to ACK_TIMEOUT
// edges, flag a sticky error and retry the full sequence on expiry.
module rst_seq #(
    parameter int NUM_DOM     = 3,
    parameter int HOLD_CYC    = 16,
    parameter int STEP_CYC    = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic     clk,
    input  logic     rst,
    rst_seq_if.slave bus
);

    localparam int MAX_A = (HOLD_CYC > STEP_CYC) ? HOLD_CYC : STEP_CYC;
    localparam int MAX_C = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
    localparam int CNT_W = $clog2(MAX_C) + 1;
    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

    typedef enum logic [1:0] {
        HOLD,
        WAIT,
        GAP,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
    logic               all_rdy_q, all_rdy_d;
    logic               busy_q, busy_d;
`ifdef RST_SEQ_TIMEOUT_EN
    logic               err_q, err_d;
`endif

    // State and registered outputs; async reset holds every domain in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            dom_rst_q <= '1;
            all_rdy_q <= 1'b0;
            busy_q    <= 1'b1;
`ifdef RST_SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            dom_rst_q <= dom_rst_d;
            all_rdy_q <= all_rdy_d;
            busy_q    <= busy_d;
`ifdef RST_SEQ_TIMEOUT_EN
            err_q     <= err_d;
`endif
        end
    end

    // Next-state and next-output computation; software request overrides all.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        dom_rst_d = dom_rst_q;
        all_rdy_d = all_rdy_q;
        busy_d    = busy_q;
`ifdef RST_SEQ_TIMEOUT_EN
        err_d     = err_q;
`endif
        if (bus.sw_rst_req) begin
            state_d   = HOLD;
            cnt_d     = '0;
            idx_d     = '0;
            dom_rst_d = '1;
            all_rdy_d = 1'b0;
            busy_d    = 1'b1;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        dom_rst_d[0] = 1'b0;
                        idx_d        = '0;
                        cnt_d        = '0;
                        state_d      = WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.dom_rdy_i[idx_q]) begin
                        if (idx_q == IDX_LAST) begin
                            state_d   = RUN;
                            all_rdy_d = 1'b1;
                            busy_d    = 1'b0;
                        end else begin
                            cnt_d   = '0;
                            state_d = GAP;
                        end
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                        err_d     = 1'b1;
                        dom_rst_d = '1;
                        cnt_d     = '0;
                        idx_d     = '0;
                        state_d   = HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
                GAP: begin
                    if (cnt_q == STEP_LAST) begin
                        for (int unsigned i = 0; i < NUM_DOM; i++) begin
                            if (IDX_W'(i) == idx_q + 1'b1) begin
                                dom_rst_d[i] = 1'b0;
                            end
                        end
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

    assign bus.dom_rst_o = dom_rst_q;
    assign bus.all_rdy_o = all_rdy_q;
    assign bus.busy_o    = busy_q;
`ifdef RST_SEQ_TIMEOUT_EN
    assign bus.err_o     = err_q;
`else
    assign bus.err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq (NUM_DOM=3, HOLD_CYC=16, STEP_CYC=4, ACK_TIMEOUT=64).
// Edge numbers in comments count from the first rising edge with rst low
// (or from the software request edge R / Q where noted).
module tb_rst_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rst_seq_if #(.NUM_DOM(3)) bus ();

    rst_seq #(
        .NUM_DOM    (3),
        .HOLD_CYC   (16),
        .STEP_CYC   (4),
        .ACK_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] rst_e, input logic rdy_e,
                           input logic busy_e, input logic err_e);
        chk({tag, ".dom_rst"}, {29'd0, bus.dom_rst_o}, {29'd0, rst_e});
        chk({tag, ".all_rdy"}, {31'd0, bus.all_rdy_o}, {31'd0, rdy_e});
        chk({tag, ".busy"},    {31'd0, bus.busy_o},    {31'd0, busy_e});
        chk({tag, ".err"},     {31'd0, bus.err_o},     {31'd0, err_e});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.sw_rst_req = 1'b0;
        bus.dom_rdy_i  = 3'b111;

        // Reset state
        step(5);
        chk_all("reset", 3'b111, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;

        // T1: nominal sequence with all readies high
        step(15);  chk_all("t1.e15", 3'b111, 1'b0, 1'b1, 1'b0);
        step(1);   chk_all("t1.e16", 3'b110, 1'b0, 1'b1, 1'b0);
        step(4);   chk_all("t1.e20", 3'b110, 1'b0, 1'b1, 1'b0);
        step(1);   chk_all("t1.e21", 3'b100, 1'b0, 1'b1, 1'b0);
        step(4);   chk_all("t1.e25", 3'b100, 1'b0, 1'b1, 1'b0);
        step(1);   chk_all("t1.e26", 3'b000, 1'b0, 1'b1, 1'b0);
        step(1);   chk_all("t1.e27", 3'b000, 1'b1, 1'b0, 1'b0);

        // RUN ignores ready deassertion
        bus.dom_rdy_i = 3'b000;
        step(5);   chk_all("run.rdy_drop", 3'b000, 1'b1, 1'b0, 1'b0);

        // T3 + T2: software request from RUN, domain 1 ready late
        bus.dom_rdy_i  = 3'b101;
        bus.sw_rst_req = 1'b1;
        step(1);   chk_all("t3.R", 3'b111, 1'b0, 1'b1, 1'b0);
        bus.sw_rst_req = 1'b0;
        step(15);  chk_all("t3.R15", 3'b111, 1'b0, 1'b1, 1'b0);
        step(1);   chk_all("t3.R16", 3'b110, 1'b0, 1'b1, 1'b0);
        step(5);   chk_all("t2.R21", 3'b100, 1'b0, 1'b1, 1'b0);
        step(9);   chk_all("t2.R30", 3'b100, 1'b0, 1'b1, 1'b0);
        bus.dom_rdy_i = 3'b111;
        step(4);   chk_all("t2.R34", 3'b100, 1'b0, 1'b1, 1'b0);
        step(1);   chk_all("t2.R35", 3'b000, 1'b0, 1'b1, 1'b0);
        step(1);   chk_all("t2.R36", 3'b000, 1'b1, 1'b0, 1'b0);

        // T4: request while HOLD count is 10 restarts the hold
        bus.sw_rst_req = 1'b1;
        step(1);
        bus.sw_rst_req = 1'b0;
        step(10);
        bus.sw_rst_req = 1'b1;
        step(1);   chk_all("t4.Q", 3'b111, 1'b0, 1'b1, 1'b0);
        bus.sw_rst_req = 1'b0;
        step(15);  chk_all("t4.Q15", 3'b111, 1'b0, 1'b1, 1'b0);
        step(1);   chk_all("t4.Q16", 3'b110, 1'b0, 1'b1, 1'b0);

        // T5: async reset while waiting on domain 1
        bus.dom_rdy_i = 3'b001;
        step(5);   chk_all("t5.Q21", 3'b100, 1'b0, 1'b1, 1'b0);
        step(3);   chk_all("t5.stall", 3'b100, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;        chk_all("t5.async", 3'b111, 1'b0, 1'b1, 1'b0);
        #1 rst = 1'b0;
        bus.dom_rdy_i = 3'b101;
        step(15);  chk_all("t5.e15", 3'b111, 1'b0, 1'b1, 1'b0);
        step(1);   chk_all("t5.e16", 3'b110, 1'b0, 1'b1, 1'b0);

        // T6: domain 1 never ready
        step(5);   chk_all("t6.e21", 3'b100, 1'b0, 1'b1, 1'b0);
        step(63);  chk_all("t6.e84", 3'b100, 1'b0, 1'b1, 1'b0);
`ifdef RST_SEQ_TIMEOUT_EN
        step(1);   chk_all("t6.timeout", 3'b111, 1'b0, 1'b1, 1'b1);
        step(15);  chk_all("t6.retry15", 3'b111, 1'b0, 1'b1, 1'b1);
        step(1);   chk_all("t6.retry16", 3'b110, 1'b0, 1'b1, 1'b1);
`else
        step(1);   chk_all("t6.e85", 3'b100, 1'b0, 1'b1, 1'b0);
        step(100); chk_all("t6.stall", 3'b100, 1'b0, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
